// File: rtl/proc_pkg.sv
// Shared types and constants for the 9-bit enhanced processor control path.
// Instruction layout: IR[8:6] opcode, IR[5:3] Rx, IR[2:0] Ry.
package proc_pkg;

    localparam int DATA_W = 9;
    localparam int OPC_W  = 3;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OPC_MV   = 3'b000;
    localparam logic [OPC_W-1:0] OPC_MVI  = 3'b001;
    localparam logic [OPC_W-1:0] OPC_ADD  = 3'b010;
    localparam logic [OPC_W-1:0] OPC_SUB  = 3'b011;
    localparam logic [OPC_W-1:0] OPC_LD   = 3'b100;
    localparam logic [OPC_W-1:0] OPC_ST   = 3'b101;
    localparam logic [OPC_W-1:0] OPC_MVNZ = 3'b110;
    localparam logic [OPC_W-1:0] OPC_NOP  = 3'b111;

    // One-hot register select for the Rin/Rout enable vectors.
    function automatic logic [7:0] reg_sel(input logic [2:0] r);
        return 8'd1 << r;
    endfunction

endpackage

// File: rtl/proc_decode.sv
// Combinational control decoder: maps the current step, instruction and
// G-nonzero flag onto every datapath control line.
module proc_decode
    import proc_pkg::*;
(
    input  state_t            state,
    input  logic [DATA_W-1:0] IR,
    input  logic              run,
    input  logic              G_nz,
    output logic [7:0]        Rin,
    output logic [7:0]        Rout,
    output logic              Ain,
    output logic              Gin,
    output logic              Gout,
    output logic              Dinout,
    output logic              AddSub,
    output logic              ADDRin,
    output logic              Doutin,
    output logic              W_D,
    output logic              incr_pc,
    output logic              done
);

    logic [OPC_W-1:0] opc;
    logic [2:0]       rx;
    logic [2:0]       ry;

    assign opc = IR[DATA_W-1 -: OPC_W];
    assign rx  = IR[5:3];
    assign ry  = IR[2:0];

    always_comb begin
        Rin     = '0;
        Rout    = '0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        Dinout  = 1'b0;
        AddSub  = 1'b0;
        ADDRin  = 1'b0;
        Doutin  = 1'b0;
        W_D     = 1'b0;
        incr_pc = 1'b0;
        done    = 1'b0;
        case (state)
            T0: begin
                if (run) begin
                    Rout   = reg_sel(3'd7);
                    ADDRin = 1'b1;
                end
            end
            T1: incr_pc = 1'b1;
            T2: ;
            T3: begin
                case (opc)
                    OPC_MV: begin
                        Rout = reg_sel(ry);
                        Rin  = reg_sel(rx);
                        done = 1'b1;
                    end
                    OPC_MVI: begin
                        Rout   = reg_sel(3'd7);
                        ADDRin = 1'b1;
                    end
                    OPC_ADD, OPC_SUB: begin
                        Rout = reg_sel(rx);
                        Ain  = 1'b1;
                    end
                    OPC_LD, OPC_ST: begin
                        Rout   = reg_sel(ry);
                        ADDRin = 1'b1;
                    end
                    OPC_MVNZ: begin
                        if (G_nz) begin
                            Rout = reg_sel(ry);
                            Rin  = reg_sel(rx);
                        end
                        done = 1'b1;
                    end
                    default: done = 1'b1;
                endcase
            end
            T4: begin
                // ld uses T4 purely as the memory read latency cycle.
                case (opc)
                    OPC_MVI: incr_pc = 1'b1;
                    OPC_ADD, OPC_SUB: begin
                        Rout   = reg_sel(ry);
                        Gin    = 1'b1;
                        AddSub = (opc == OPC_SUB);
                    end
                    OPC_ST: begin
                        Rout   = reg_sel(rx);
                        Doutin = 1'b1;
                        W_D    = 1'b1;
                        done   = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (opc)
                    OPC_MVI, OPC_LD: begin
                        Dinout = 1'b1;
                        Rin    = reg_sel(rx);
                        done   = 1'b1;
                    end
                    OPC_ADD, OPC_SUB: begin
                        Gout = 1'b1;
                        Rin  = reg_sel(rx);
                        done = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/proc_control.sv
// Multi-cycle control FSM: holds the step register and the instruction
// register, and sequences fetch/execute through the decoder.
module proc_control
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] Din,
    input  logic              G_nz,
    output logic [7:0]        Rin,
    output logic [7:0]        Rout,
    output logic              Ain,
    output logic              Gin,
    output logic              Gout,
    output logic              Dinout,
    output logic              AddSub,
    output logic              ADDRin,
    output logic              Doutin,
    output logic              W_D,
    output logic              incr_pc,
    output logic              done,
    output logic [DATA_W-1:0] IR
);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] ir_q;

    assign IR = ir_q;

    proc_decode u_decode (
        .state   (state),
        .IR      (ir_q),
        .run     (run),
        .G_nz    (G_nz),
        .Rin     (Rin),
        .Rout    (Rout),
        .Ain     (Ain),
        .Gin     (Gin),
        .Gout    (Gout),
        .Dinout  (Dinout),
        .AddSub  (AddSub),
        .ADDRin  (ADDRin),
        .Doutin  (Doutin),
        .W_D     (W_D),
        .incr_pc (incr_pc),
        .done    (done)
    );

    // The decoder's done flag marks the final step of every instruction,
    // so execute steps return to T0 on done and otherwise advance.
    always_comb begin
        next_state = T0;
        case (state)
            T0:      next_state = run ? T1 : T0;
            T1:      next_state = T2;
            T2:      next_state = T3;
            T3:      next_state = done ? T0 : T4;
            T4:      next_state = done ? T0 : T5;
            T5:      next_state = T0;
            default: next_state = T0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= T0;
            ir_q  <= '0;
        end else begin
            state <= next_state;
            if (state == T2) begin
                ir_q <= Din;
            end
        end
    end

endmodule

// File: tb/tb_proc_control.sv
// Randomized self-checking bench for proc_control: each instruction's
// expected control-word script is built from the opcode table and compared per cycle.
module tb_proc_control;

    typedef struct packed {
        logic [7:0] rin;
        logic [7:0] rout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic       dinout;
        logic       addsub;
        logic       addrin;
        logic       doutin;
        logic       wd;
        logic       incrpc;
        logic       done;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       G_nz;
    logic [8:0] Din;
    logic [7:0] Rin;
    logic [7:0] Rout;
    logic       Ain, Gin, Gout, Dinout, AddSub, ADDRin, Doutin, W_D, incr_pc, done;
    logic [8:0] IR;

    int compared   = 0;
    int mismatched = 0;
    int instrNo    = 0;

    always #5 clk = ~clk;

    proc_control dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .Din     (Din),
        .G_nz    (G_nz),
        .Rin     (Rin),
        .Rout    (Rout),
        .Ain     (Ain),
        .Gin     (Gin),
        .Gout    (Gout),
        .Dinout  (Dinout),
        .AddSub  (AddSub),
        .ADDRin  (ADDRin),
        .Doutin  (Doutin),
        .W_D     (W_D),
        .incr_pc (incr_pc),
        .done    (done),
        .IR      (IR)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic ctl_t observedCtl();
        ctl_t c;
        c.rin    = Rin;
        c.rout   = Rout;
        c.ain    = Ain;
        c.gin    = Gin;
        c.gout   = Gout;
        c.dinout = Dinout;
        c.addsub = AddSub;
        c.addrin = ADDRin;
        c.doutin = Doutin;
        c.wd     = W_D;
        c.incrpc = incr_pc;
        c.done   = done;
        return c;
    endfunction

    // Inputs are driven at the falling edge; outputs are sampled 1ns later.
    task automatic checkCycle(input string tag, input ctl_t expected);
        int drivers;
        logic ruleOk;
        #1;
        checkOutput({tag, ".ctl"}, 32'(observedCtl()), 32'(expected));
        drivers = $countones(Rout) + int'(Gout) + int'(Dinout);
        ruleOk  = (drivers <= 1) && !(incr_pc && Rin[7]);
        checkOutput({tag, ".bus"}, 32'(ruleOk), 32'd1);
        @(negedge clk);
    endtask

    // Runs one instruction; abortAt >= 0 asserts rst during that step index.
    task automatic applyStimulus(input logic [8:0] instr, input logic gnz, input int abortAt);
        ctl_t q[$];
        ctl_t c;
        logic [2:0] opc;
        logic [7:0] rxSel;
        logic [7:0] rySel;
        string tag;
        opc   = instr[8:6];
        rxSel = 8'd1 << instr[5:3];
        rySel = 8'd1 << instr[2:0];

        c = '0; c.rout = 8'h80; c.addrin = 1'b1; q.push_back(c);
        c = '0; c.incrpc = 1'b1; q.push_back(c);
        c = '0; q.push_back(c);
        case (opc)
            3'b000: begin
                c = '0; c.rout = rySel; c.rin = rxSel; c.done = 1'b1; q.push_back(c);
            end
            3'b001: begin
                c = '0; c.rout = 8'h80; c.addrin = 1'b1; q.push_back(c);
                c = '0; c.incrpc = 1'b1; q.push_back(c);
                c = '0; c.dinout = 1'b1; c.rin = rxSel; c.done = 1'b1; q.push_back(c);
            end
            3'b010, 3'b011: begin
                c = '0; c.rout = rxSel; c.ain = 1'b1; q.push_back(c);
                c = '0; c.rout = rySel; c.gin = 1'b1; c.addsub = (opc == 3'b011); q.push_back(c);
                c = '0; c.gout = 1'b1; c.rin = rxSel; c.done = 1'b1; q.push_back(c);
            end
            3'b100: begin
                c = '0; c.rout = rySel; c.addrin = 1'b1; q.push_back(c);
                c = '0; q.push_back(c);
                c = '0; c.dinout = 1'b1; c.rin = rxSel; c.done = 1'b1; q.push_back(c);
            end
            3'b101: begin
                c = '0; c.rout = rySel; c.addrin = 1'b1; q.push_back(c);
                c = '0; c.rout = rxSel; c.doutin = 1'b1; c.wd = 1'b1; c.done = 1'b1; q.push_back(c);
            end
            3'b110: begin
                c = '0;
                if (gnz) begin
                    c.rout = rySel;
                    c.rin  = rxSel;
                end
                c.done = 1'b1;
                q.push_back(c);
            end
            default: begin
                c = '0; c.done = 1'b1; q.push_back(c);
            end
        endcase

        instrNo++;
        for (int i = 0; i < q.size(); i++) begin
            rst  = (i == abortAt);
            run  = (i == 0) ? 1'b1 : 1'($urandom);
            G_nz = gnz;
            Din  = (i == 2) ? instr : 9'($urandom);
            tag  = $sformatf("i%0d.s%0d", instrNo, i);
            if (i == 3) begin
                #1;
                checkOutput({tag, ".ir"}, 32'(IR), 32'(instr));
                #0;
            end
            checkCycle(tag, q[i]);
            if (i == abortAt) begin
                rst = 1'b0;
                run = 1'b0;
                #1;
                checkOutput($sformatf("i%0d.rst.ir", instrNo), 32'(IR), 32'd0);
                checkCycle($sformatf("i%0d.rst.idle", instrNo), '0);
                break;
            end
        end
        rst = 1'b0;
    endtask

    task automatic idleCycles(input int n, input logic [8:0] lastInstr);
        for (int i = 0; i < n; i++) begin
            rst  = 1'b0;
            run  = 1'b0;
            G_nz = 1'($urandom);
            Din  = 9'($urandom);
            #1;
            checkOutput($sformatf("idle%0d.ir", instrNo), 32'(IR), 32'(lastInstr));
            checkCycle($sformatf("idle%0d.%0d", instrNo, i), '0);
        end
    endtask

    initial begin
        logic [8:0] instr;
        logic       gnz;
        rst  = 1'b1;
        run  = 1'b1;
        G_nz = 1'b0;
        Din  = 9'h1FF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        #1;
        checkOutput("reset.ir", 32'(IR), 32'd0);
        checkCycle("reset.idle", '0);
        idleCycles(2, 9'h000);

        applyStimulus(9'b001_000_000, 1'b0, -1);
        applyStimulus(9'b010_000_001, 1'b0, -1);
        applyStimulus(9'b011_000_001, 1'b1, -1);
        applyStimulus(9'b101_010_011, 1'b0, -1);
        applyStimulus(9'b100_100_011, 1'b0, -1);
        applyStimulus(9'b110_101_110, 1'b0, -1);
        applyStimulus(9'b110_101_110, 1'b1, -1);
        applyStimulus(9'b111_000_000, 1'b0, -1);
        applyStimulus(9'b000_111_010, 1'b0, -1);
        idleCycles(3, 9'b000_111_010);

        applyStimulus(9'b010_000_001, 1'b0, 4);
        idleCycles(3, 9'h000);

        for (int n = 0; n < 200; n++) begin
            instr = 9'($urandom);
            gnz   = 1'($urandom);
            applyStimulus(instr, gnz, -1);
            if ($urandom_range(0, 7) == 0) begin
                idleCycles($urandom_range(1, 3), instr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
